// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: shared constants for the SD command-line engine.
package sd_cmd_pkg;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TX   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_RX   = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;
    localparam logic [1:0] RSP_NONE = 2'b00;
    localparam logic [1:0] RSP_48   = 2'b01;
    localparam logic [1:0] RSP_136  = 2'b10;
    localparam int TX_LEN   = 48;
    localparam int LEN_48   = 48;
    localparam int LEN_136  = 136;
    localparam int CRC_BITS = 40;
    localparam logic [6:0] CRC7_POLY = 7'h09;
endpackage

// File: rtl/sd_crc_7.sv
// sd_crc_7: serial CRC7 (x^7+x^3+1), MSB-first input, zero initial value.
module sd_crc_7 (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       CLR,
    input  logic       BIT_IN,
    output logic [6:0] CRC
);
    import sd_cmd_pkg::*;
    logic fb;
    assign fb = BIT_IN ^ CRC[6];
    always_ff @(posedge CLK or posedge RST)
        if (RST) CRC <= 7'd0;
        else if (CLR) CRC <= 7'd0;
        else if (EN) CRC <= {CRC[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
endmodule

// File: rtl/sd_cmd_serial_host.sv
// sd_cmd_serial_host: SD CMD line engine; sends a 48-bit command with CRC7 and
// optionally captures a 48/136-bit response with CRC, end-bit and timeout checks.
module sd_cmd_serial_host #(
    parameter int TIMEOUT = 64,
    parameter int NCC = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [5:0]   CMD_INDEX,
    input  logic [31:0]  CMD_ARG,
    input  logic [1:0]   RSP_TYPE,
    input  logic         CMD_I,
    output logic         CMD_O,
    output logic         CMD_OE,
    output logic         BUSY,
    output logic         DONE,
    output logic [5:0]   RSP_INDEX,
    output logic [127:0] RSP_DATA,
    output logic         CRC_ERR,
    output logic         END_ERR,
    output logic         TIMEOUT_ERR
);
    import sd_cmd_pkg::*;
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [2:0]    state;
    logic [7:0]    cnt;
    logic [WW-1:0] wcnt;
    logic [39:0]   frame;
    logic [1:0]    rtype;
    logic [126:0]  sr;
    logic [127:0]  nxt;
    logic [6:0]    crc;
    logic [7:0]    len_m1;
    logic [7:0]    pos;
    logic          is_long;
    logic          crc_en;
    logic          crc_clr;
    logic          crc_bit;

    assign is_long = rtype == RSP_136;
    assign len_m1 = is_long ? 8'(LEN_136 - 1) : 8'(LEN_48 - 1);
    assign pos = len_m1 - cnt;
    assign nxt = {sr, CMD_I};
    // The response start bit is 0, so clearing through WAIT equals feeding it.
    assign crc_clr = state == S_IDLE || state == S_WAIT;
    assign crc_bit = state == S_TX ? frame[39] : CMD_I;
    assign crc_en = (state == S_TX && cnt < 8'(CRC_BITS)) ||
                    (state == S_RX && pos >= 8'd8 && (!is_long || pos <= 8'd127));
    assign CMD_OE = state == S_TX;
    assign CMD_O = state != S_TX ? 1'b1 :
                   cnt < 8'(CRC_BITS) ? frame[39] :
                   cnt < 8'(TX_LEN - 1) ? crc[3'(8'(TX_LEN - 2) - cnt)] : 1'b1;
    assign BUSY = state != S_IDLE;
    assign DONE = state == S_GAP && cnt == 8'(NCC);

    sd_crc_7 u_crc (
        .CLK(CLK), .RST(RST), .EN(crc_en), .CLR(crc_clr), .BIT_IN(crc_bit), .CRC(crc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            cnt <= 8'd0;
            wcnt <= '0;
            frame <= 40'd0;
            rtype <= RSP_NONE;
            sr <= '0;
            RSP_INDEX <= 6'd0;
            RSP_DATA <= 128'd0;
            CRC_ERR <= 1'b0;
            END_ERR <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else if (state == S_IDLE) begin
            if (START) begin
                frame <= {2'b01, CMD_INDEX, CMD_ARG};
                rtype <= (RSP_TYPE == RSP_48 || RSP_TYPE == RSP_136) ? RSP_TYPE : RSP_NONE;
                cnt <= 8'd0;
                RSP_INDEX <= 6'd0;
                RSP_DATA <= 128'd0;
                CRC_ERR <= 1'b0;
                END_ERR <= 1'b0;
                TIMEOUT_ERR <= 1'b0;
                state <= S_TX;
            end
        end else if (state == S_TX) begin
            frame <= {frame[38:0], 1'b0};
            cnt <= cnt + 8'd1;
            if (cnt == 8'(TX_LEN - 1)) begin
                cnt <= 8'd0;
                wcnt <= '0;
                state <= rtype != RSP_NONE ? S_WAIT : S_GAP;
            end
        end else if (state == S_WAIT) begin
            if (!CMD_I) begin
                cnt <= 8'd1;
                state <= S_RX;
            end else if (wcnt == WW'(TIMEOUT - 1)) begin
                TIMEOUT_ERR <= 1'b1;
                cnt <= 8'd0;
                state <= S_GAP;
            end else begin
                wcnt <= wcnt + 1'b1;
            end
        end else if (state == S_RX) begin
            sr <= nxt[126:0];
            cnt <= cnt + 8'd1;
            if (cnt == len_m1) begin
                CRC_ERR <= crc != nxt[7:1];
                END_ERR <= !nxt[0];
                RSP_INDEX <= is_long ? 6'd0 : nxt[45:40];
                RSP_DATA <= is_long ? nxt : {96'd0, nxt[39:8]};
                cnt <= 8'd0;
                state <= S_GAP;
            end
        end else if (state == S_GAP) begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'(NCC)) begin
                cnt <= 8'd0;
                state <= S_IDLE;
            end
        end else begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_sd_cmd_serial_host.sv
// tb_sd_cmd_serial_host: scoreboard bench for the SD CMD line engine.
module tb_sd_cmd_serial_host;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [5:0]   cmd_index = 6'd0;
    logic [31:0]  cmd_arg = 32'd0;
    logic [1:0]   rsp_type = 2'd0;
    logic         cmd_i = 1'b1;
    logic         cmd_o, cmd_oe, busy, done, crc_err, end_err, timeout_err;
    logic [5:0]   rsp_index;
    logic [127:0] rsp_data;
    int           npass = 0;
    int           ntot = 0;

    typedef struct {
        logic [47:0]  frame;
        logic [5:0]   idx;
        logic [127:0] data;
        logic         ce;
        logic         ee;
        logic         te;
        int           done_c;
        int           to_c;
    } exp_t;
    exp_t sb[$];

    sd_cmd_serial_host dut (
        .CLK(clk), .RST(rst), .START(start), .CMD_INDEX(cmd_index), .CMD_ARG(cmd_arg),
        .RSP_TYPE(rsp_type), .CMD_I(cmd_i), .CMD_O(cmd_o), .CMD_OE(cmd_oe), .BUSY(busy),
        .DONE(done), .RSP_INDEX(rsp_index), .RSP_DATA(rsp_data), .CRC_ERR(crc_err),
        .END_ERR(end_err), .TIMEOUT_ERR(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] crc7(input logic [135:0] v, input int n);
        logic [6:0] c = 7'd0;
        logic fb;
        for (int i = n - 1; i >= 0; i--) begin
            fb = v[i] ^ c[6];
            c = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic exp_t mk(input logic [47:0] f, input logic [5:0] i, input logic [127:0] d,
                                input logic ce, input logic ee, input logic te, input int dc, input int tc);
        exp_t e;
        e.frame = f; e.idx = i; e.data = d; e.ce = ce; e.ee = ee; e.te = te;
        e.done_c = dc; e.to_c = tc;
        return e;
    endfunction

    // Cycle 0 is the cycle START is high; cycle c is observed at its negedge.
    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                          input int d, input int rlen, input logic [135:0] rsp, input bit poke,
                          input exp_t e);
        int c, oe_tx, oe_all, done_c, to_c;
        logic [47:0] got;
        exp_t x;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; cmd_index = idx; cmd_arg = arg; rsp_type = rt;
        @(negedge clk);
        c = 1; start = 1'b0; cmd_index = ~idx; cmd_arg = ~arg; rsp_type = ~rt;
        got = 48'd0; oe_tx = 0; oe_all = 0; done_c = -1; to_c = -1;
        ntot++; if (busy !== 1'b1) $display("FAIL busy_after_start got=%b exp=1", busy); else npass++;
        for (int i = 0; i < 48; i++) begin
            if (i > 0) begin @(negedge clk); c++; end
            start = poke && i == 10;
            got = {got[46:0], cmd_o};
            oe_tx += int'(cmd_oe);
        end
        for (int j = 0; j < d + rlen; j++) begin
            @(negedge clk); c++;
            start = poke;
            oe_all += int'(cmd_oe);
            cmd_i = j < d ? 1'b1 : rsp[rlen - 1 - (j - d)];
        end
        for (int n = 0; n < 300 && done_c < 0; n++) begin
            @(negedge clk); c++;
            start = poke;
            cmd_i = 1'b1;
            oe_all += int'(cmd_oe);
            if (timeout_err === 1'b1 && to_c < 0) to_c = c;
            if (done === 1'b1) done_c = c;
        end
        x = sb.pop_front();
        ntot++; if (got !== x.frame) $display("FAIL tx_frame got=%h exp=%h", got, x.frame); else npass++;
        ntot++; if (oe_tx !== 48) $display("FAIL oe_tx_cycles got=%0d exp=48", oe_tx); else npass++;
        ntot++; if (oe_all !== 0) $display("FAIL oe_after_tx got=%0d exp=0", oe_all); else npass++;
        ntot++; if (done_c !== x.done_c) $display("FAIL done_cycle got=%0d exp=%0d", done_c, x.done_c); else npass++;
        ntot++; if (to_c !== x.to_c) $display("FAIL timeout_cycle got=%0d exp=%0d", to_c, x.to_c); else npass++;
        ntot++; if (rsp_index !== x.idx) $display("FAIL rsp_index got=%h exp=%h", rsp_index, x.idx); else npass++;
        ntot++; if (rsp_data !== x.data) $display("FAIL rsp_data got=%h exp=%h", rsp_data, x.data); else npass++;
        ntot++; if ({crc_err, end_err, timeout_err} !== {x.ce, x.ee, x.te})
            $display("FAIL flags crc/end/to got=%b%b%b exp=%b%b%b", crc_err, end_err, timeout_err, x.ce, x.ee, x.te);
        else npass++;
        @(negedge clk);
        start = 1'b0;
        ntot++; if ({busy, done} !== 2'b00) $display("FAIL idle_after_done busy/done got=%b%b exp=00", busy, done); else npass++;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        ntot++; if ({cmd_o, cmd_oe, busy, done} !== 4'b1000)
            $display("FAIL reset_ctrl o/oe/busy/done got=%b%b%b%b exp=1000", cmd_o, cmd_oe, busy, done);
        else npass++;
        ntot++; if ({rsp_index, rsp_data, crc_err, end_err, timeout_err} !== 137'd0)
            $display("FAIL reset_rsp got=%h/%h/%b%b%b exp=0", rsp_index, rsp_data, crc_err, end_err, timeout_err);
        else npass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_rsp;
        do_cmd(6'd0, 32'd0, 2'b00, 0, 0, 136'd0, 1'b0,
               mk(48'h40_0000_0000_95, 6'd0, 128'd0, 0, 0, 0, 57, -1));
    endtask

    task automatic test_rsp48;
        do_cmd(6'd8, 32'h1AA, 2'b01, 4, 48, {88'd0, 48'h08_0000_01AA_13}, 1'b0,
               mk(48'h48_0000_01AA_87, 6'd8, 128'h1AA, 0, 0, 0, 109, -1));
        do_cmd(6'd8, 32'h1AA, 2'b01, 4, 48, {88'd0, 48'h08_0000_01AA_15}, 1'b0,
               mk(48'h48_0000_01AA_87, 6'd8, 128'h1AA, 1, 0, 0, 109, -1));
        do_cmd(6'd8, 32'h1AA, 2'b01, 4, 48, {88'd0, 48'h08_0000_01AA_12}, 1'b0,
               mk(48'h48_0000_01AA_87, 6'd8, 128'h1AA, 0, 1, 0, 109, -1));
    endtask

    task automatic test_rsp136;
        logic [119:0] cid;
        logic [135:0] r;
        cid = 120'h03534453443136478012345678_0137;
        r = {8'h3F, cid, crc7({16'd0, cid}, 120), 1'b1};
        do_cmd(6'd2, 32'd0, 2'b10, 2, 136, r, 1'b0,
               mk(48'h42_0000_0000_4D, 6'd0, r[127:0], 0, 0, 0, 195, -1));
        do_cmd(6'd8, 32'h1AA, 2'b01, 0, 0, 136'd0, 1'b0,
               mk(48'h48_0000_01AA_87, 6'd0, 128'd0, 0, 0, 1, 121, 113));
    endtask

    task automatic test_boundary;
        do_cmd(6'd8, 32'h1AA, 2'b01, 63, 48, {88'd0, 48'h08_0000_01AA_13}, 1'b0,
               mk(48'h48_0000_01AA_87, 6'd8, 128'h1AA, 0, 0, 0, 168, -1));
        do_cmd(6'd0, 32'd0, 2'b00, 0, 0, 136'd0, 1'b1,
               mk(48'h40_0000_0000_95, 6'd0, 128'd0, 0, 0, 0, 57, -1));
    endtask

    task automatic test_reset_mid;
        int spurious;
        @(negedge clk);
        start = 1'b1; cmd_index = 6'd17; cmd_arg = 32'd0; rsp_type = 2'b00;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        ntot++; if ({cmd_oe, busy, cmd_o} !== 3'b001)
            $display("FAIL async_abort oe/busy/o got=%b%b%b exp=001", cmd_oe, busy, cmd_o);
        else npass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        repeat (70) begin
            @(negedge clk);
            spurious += int'(done) + int'(cmd_oe) + int'(busy);
        end
        ntot++; if (spurious !== 0) $display("FAIL after_abort activity got=%0d exp=0", spurious); else npass++;
        do_cmd(6'd17, 32'd0, 2'b00, 0, 0, 136'd0, 1'b0,
               mk(48'h51_0000_0000_55, 6'd0, 128'd0, 0, 0, 0, 57, -1));
    endtask

    initial begin
        test_reset;
        test_no_rsp;
        test_rsp48;
        test_rsp136;
        test_boundary;
        test_reset_mid;
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/sd_cmd_serial_host.md
Name: sd_cmd_serial_host

Overview:
- Command-line (CMD) engine for the SD host. Runs in the SD clock domain produced by SD_CLOCK_DIVIDER: its CLK port is wired to that block's SD_CLK output.
- Serialises a 48-bit SD command frame with generated CRC7, then optionally captures a 48- or 136-bit card response.
- Checks the response CRC, end bit and timeout, and reports status to the register/DMA layer.

Parameters:
- TIMEOUT, 64, number of SD_CLK cycles to wait for a response start bit (NCR limit).
- NCC, 8, idle SD_CLK cycles inserted after each transaction before DONE.

Ports:
- CLK  in  1  SD clock (SD_CLK from the clock divider)
- RST  in  1  asynchronous, active-high reset
- START  in  1  single-cycle request; sampled only in IDLE
- CMD_INDEX  in  6  command index
- CMD_ARG  in  32  command argument
- RSP_TYPE  in  2  00 none, 01 48-bit, 10 136-bit, 11 treated as 00
- CMD_I  in  1  sampled CMD line (pulled high when idle)
- CMD_O  out  1  CMD line drive value
- CMD_OE  out  1  CMD line output enable
- BUSY  out  1  high from START acceptance until DONE
- DONE  out  1  one-cycle completion pulse
- RSP_INDEX  out  6  response bits 45:40 (48-bit responses only)
- RSP_DATA  out  128  48-bit: [31:0] = bits 39:8, upper bits 0; 136-bit: bits 127:0
- CRC_ERR  out  1  response CRC7 mismatch
- END_ERR  out  1  response end bit was 0
- TIMEOUT_ERR  out  1  no start bit within TIMEOUT cycles

Behaviour:
- Reset: all outputs 0, CMD_O = 1, state IDLE, counters cleared.
- Reset mid-operation aborts immediately (CMD_OE falls asynchronously); no DONE is produced.
- All logic runs on posedge CLK.
- TX frame, MSB first: 0 (start), 1 (host), CMD_INDEX, CMD_ARG, CRC7[6:0], 1 (end).
- CRC7 polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits.
- States: IDLE -> TX -> (WAIT -> RX ->) GAP -> IDLE.
- IDLE:
  - On START=1, latch all inputs, clear every status flag and RSP_*, set BUSY, go to TX.
  - START is ignored in every other state.
- TX:
  - CMD_OE=1 for exactly 48 cycles, starting the cycle after START is sampled.
  - CMD_O presents one frame bit per cycle.
  - After the last bit, CMD_OE=0. Go to WAIT if RSP_TYPE is 01/10, else GAP.
- WAIT:
  - Sample CMD_I each cycle. The first 0 is the start bit: go to RX.
  - After TIMEOUT consecutive samples of 1: set TIMEOUT_ERR, go to GAP.
  - A start bit on the TIMEOUT-th sample is accepted (not a timeout).
- RX:
  - Shift in the remaining 47 (type 01) or 135 (type 10) bits.
  - CRC check: type 01 covers bits 47:8 against 7:1; type 10 covers bits 127:8 against 7:1.
  - On the final bit, set CRC_ERR and END_ERR as applicable, update RSP_INDEX/RSP_DATA, go to GAP.
  - Response fields and flags are valid from DONE and held until the next accepted START.
- GAP: NCC cycles with CMD_OE=0. Then DONE=1 for one cycle, BUSY=0, back to IDLE.
- Latency: a no-response command with START sampled at cycle 0 drives cycles 1..48, gaps 49..56, DONE at cycle 57.
- START on the cycle DONE is high is not accepted (state is still GAP); it is accepted on the following cycle.
- Counters: bit counter 8 bits (max 135); wait counter sized $clog2(TIMEOUT+1).

Decomposition:
- Package sd_cmd_pkg:
  - state enum (IDLE, TX, WAIT, RX, GAP)
  - RSP_TYPE codes
  - frame lengths 48/136
  - CRC7 polynomial constant
- Sub-module sd_crc_7:
  - Serial CRC7 with ports CLK, RST, EN, CLR, BIT_IN, CRC[6:0].
  - One instance, shared by TX and RX, cleared at the start of each frame.

Test Plan:
- CMD0 (index 0, arg 0, RSP_TYPE 00) -> CMD_O bytes 40 00 00 00 00 95; CMD_OE high cycles 1..48; DONE at cycle 57; no flags set.
- CMD8 (arg 0x000001AA, type 01), card returns 08 00 00 01 AA 13 starting 5 cycles after TX -> TX CRC byte 87; RSP_INDEX=8; RSP_DATA[31:0]=0x000001AA; CRC_ERR=END_ERR=0.
- Same as CMD8 case but response CRC byte 0x15 -> CRC_ERR=1. Then a response with end bit 0 -> END_ERR=1, CRC_ERR=0.
- CMD2 (type 10), 136-bit response with a known CID and valid CRC -> RSP_DATA matches bits 127:0, no errors. Then hold CMD_I=1 -> TIMEOUT_ERR=1 exactly after 64 wait cycles, DONE 8 cycles later.
- Boundary timing:
  - Start bit arriving on wait cycle 64 is accepted.
  - START pulses during BUSY are ignored (no second frame).
  - RST asserted at TX bit 20 -> CMD_OE=0 immediately, BUSY=0, no DONE.
  - A fresh CMD17 after release gives bytes 51 00 00 00 00 55.
